// File: rtl/risc16_dual_port_memory.sv
// risc16_dual_port_memory: port A fetch read, port B data read/write.
// Define RISC16_MEM_CLEAR_EN to build the one-word-per-cycle clear engine.
module risc16_dual_port_memory #(
    parameter int WORD_LENGTH = 16,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic [ADDR_WIDTH-1:0]  a_addr,
    output logic [WORD_LENGTH-1:0] a_rdata,
    output logic                   a_valid,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [WORD_LENGTH-1:0] b_wdata,
    output logic [WORD_LENGTH-1:0] b_rdata,
    output logic                   b_valid,
    input  logic                   clear_req,
    output logic                   ready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_LENGTH-1:0] mem [DEPTH];
    logic                   aAcc;
    logic                   bAcc;
    logic                   memWe;
    logic [ADDR_WIDTH-1:0]  memAddr;
    logic [WORD_LENGTH-1:0] memWdata;

    assign aAcc = a_req & ready;
    assign bAcc = b_req & ready;

`ifdef RISC16_MEM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    state_t                state;
    state_t                stateNext;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] counterNext;
    logic                  clrWe;
    logic                  lastWord;

    assign lastWord = (counter == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
        end
    end

    // Leaving CLEAR on the terminal word stops the sweep without a wider counter
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    stateNext   = CLEAR;
                    counterNext = '0;
                end
            end
            CLEAR: begin
                counterNext = counter + ONE;
                if (lastWord) stateNext = IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        clrWe = (state == CLEAR);
    end

    // Ports are blocked during a sweep, so the two writers never collide
    always_comb begin
        memWe    = rst & (clrWe | (bAcc & b_we));
        memAddr  = clrWe ? counter : b_addr;
        memWdata = clrWe ? '0 : b_wdata;
    end
`else
    logic unusedClearReq;
    assign unusedClearReq = clear_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready <= 1'b0;
        else      ready <= 1'b1;
    end

    always_comb begin
        memWe    = rst & bAcc & b_we;
        memAddr  = b_addr;
        memWdata = b_wdata;
    end
`endif

    always_ff @(posedge clk) begin
        if (memWe) mem[memAddr] <= memWdata;
    end

    // Reads sample the array before this edge's write lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata <= '0;
            a_valid <= 1'b0;
            b_rdata <= '0;
            b_valid <= 1'b0;
        end else begin
            a_valid <= aAcc;
            b_valid <= bAcc;
            if (aAcc) a_rdata <= mem[a_addr];
            if (bAcc && !b_we) b_rdata <= mem[b_addr];
        end
    end
endmodule

// File: tb/tb_risc16_dual_port_memory.sv
// tb_risc16_dual_port_memory: random and directed checks of the
// two-port memory against an array model, ADDR_WIDTH=4.
module tb_risc16_dual_port_memory;
    logic        clk;
    logic        rst;
    logic        a_req;
    logic [3:0]  a_addr;
    logic [15:0] a_rdata;
    logic        a_valid;
    logic        b_req;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [15:0] b_wdata;
    logic [15:0] b_rdata;
    logic        b_valid;
    logic        clear_req;
    logic        ready;

    int checks = 0;
    int errors = 0;

    risc16_dual_port_memory #(
        .WORD_LENGTH(16),
        .ADDR_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_req(a_req),
        .a_addr(a_addr),
        .a_rdata(a_rdata),
        .a_valid(a_valid),
        .b_req(b_req),
        .b_we(b_we),
        .b_addr(b_addr),
        .b_wdata(b_wdata),
        .b_rdata(b_rdata),
        .b_valid(b_valid),
        .clear_req(clear_req),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: word array, known flags, sweep words remaining
    logic [15:0] mMem [16];
    bit          mKnown [16];
    int          mBusy;
    bit          mUp;
    logic [15:0] eAData, eBData;
    bit          eAKnown, eBKnown, eAValid, eBValid, eReady;
    bit          rdy, accA, accB;

    initial begin
        for (int i = 0; i < 16; i++) mKnown[i] = 1'b0;
`ifdef RISC16_MEM_CLEAR_EN
        mBusy = 16;
`else
        mBusy = 0;
`endif
        mUp = 1'b0;
        eAData = '0; eBData = '0;
        eAKnown = 1'b1; eBKnown = 1'b1;
        eAValid = 1'b0; eBValid = 1'b0; eReady = 1'b0;
    end

    always @(negedge rst) begin
        eAData = '0; eBData = '0;
        eAKnown = 1'b1; eBKnown = 1'b1;
        eAValid = 1'b0; eBValid = 1'b0; eReady = 1'b0;
        mUp = 1'b0;
`ifdef RISC16_MEM_CLEAR_EN
        mBusy = 16;
`endif
    end

    always @(posedge clk) begin
        if (!rst) begin
            eAData = '0; eBData = '0;
            eAKnown = 1'b1; eBKnown = 1'b1;
            eAValid = 1'b0; eBValid = 1'b0; eReady = 1'b0;
            mUp = 1'b0;
`ifdef RISC16_MEM_CLEAR_EN
            mBusy = 16;
`endif
        end else begin
`ifdef RISC16_MEM_CLEAR_EN
            rdy = (mBusy == 0);
`else
            rdy = mUp;
`endif
            accA = a_req && rdy;
            accB = b_req && rdy;
            eAValid = accA;
            eBValid = accB;
            if (accA) begin
                eAKnown = mKnown[a_addr];
                eAData  = mMem[a_addr];
            end
            if (accB && !b_we) begin
                eBKnown = mKnown[b_addr];
                eBData  = mMem[b_addr];
            end
            if (accB && b_we) begin
                mMem[b_addr]   = b_wdata;
                mKnown[b_addr] = 1'b1;
            end
`ifdef RISC16_MEM_CLEAR_EN
            if (mBusy > 0) begin
                mMem[16-mBusy]   = '0;
                mKnown[16-mBusy] = 1'b1;
                mBusy--;
            end else if (clear_req) begin
                mBusy = 16;
            end
            eReady = (mBusy == 0);
`else
            mUp = 1'b1;
            eReady = 1'b1;
`endif
        end
        #1;
        chk("a_valid", a_valid, eAValid);
        chk("b_valid", b_valid, eBValid);
        chk("ready", ready, eReady);
        if (eAKnown) chk("a_rdata", a_rdata, eAData);
        if (eBKnown) chk("b_rdata", b_rdata, eBData);
    end

    task automatic drive(bit ar, logic [3:0] aa, bit br, bit bw,
                         logic [3:0] ba, logic [15:0] bd, bit cr);
        a_req = ar; a_addr = aa;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        clear_req = cr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic waitReady(string nm, output int n);
        n = 0;
        while (!ready && n < 100) begin
            n++;
            idle();
        end
        if (n >= 100) chk({nm, "_timeout"}, 0, 1);
    endtask

    int n;

    initial begin
        rst = 1'b0;
        a_req = 0; a_addr = 0; b_req = 0; b_we = 0;
        b_addr = 0; b_wdata = 0; clear_req = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 0);
        chk("reset_a_rdata", a_rdata, 0);
        rst = 1'b1;

        n = 0;
        while (!ready && n < 100) begin
            n++;
            if (n == 3) drive(0, 0, 1, 1, 2, 16'h00AA, 0);
            else idle();
        end
`ifdef RISC16_MEM_CLEAR_EN
        chk("sweep_len", n, 16);
        for (int i = 0; i < 16; i++) drive(1, 4'(i), 0, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 0);
        chk("dropped_write", a_rdata, 16'h0000);
`else
        chk("ready_rise", n, 1);
`endif

        drive(0, 0, 1, 1, 5, 16'hBEEF, 0);
        chk("wr_bvalid", b_valid, 1);
        drive(1, 5, 1, 0, 5, 0, 0);
        chk("rd_a", a_rdata, 16'hBEEF);
        chk("rd_b", b_rdata, 16'hBEEF);
        chk("rd_avalid", a_valid, 1);
        idle();
        chk("avalid_pulse", a_valid, 0);

        drive(0, 0, 1, 1, 3, 16'h1111, 0);
        drive(1, 3, 1, 1, 3, 16'h2222, 0);
        chk("collision_old", a_rdata, 16'h1111);
        drive(1, 3, 0, 0, 0, 0, 0);
        chk("collision_new", a_rdata, 16'h2222);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 49) == 0);
        end
        waitReady("rand", n);

`ifdef RISC16_MEM_CLEAR_EN
        drive(0, 0, 1, 1, 7, 16'h1234, 0);
        drive(1, 7, 0, 0, 0, 0, 0);
        chk("fill7", a_rdata, 16'h1234);
        drive(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        while (!ready && n < 100) begin
            n++;
            drive(0, 0, 0, 0, 0, 0, n == 5);
        end
        chk("clear_len", n, 16);
        drive(1, 7, 0, 0, 0, 0, 0);
        chk("cleared7", a_rdata, 16'h0000);

        drive(0, 0, 1, 1, 9, 16'hABCD, 0);
        drive(1, 9, 0, 0, 0, 0, 0);
        chk("fill9", a_rdata, 16'hABCD);
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (8) idle();
        #2 rst = 1'b0;
        #1;
        chk("midsweep_a_rdata", a_rdata, 0);
        chk("midsweep_ready", ready, 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            n++;
            idle();
        end
        chk("resweep_len", n, 16);
`endif

        drive(0, 0, 1, 1, 11, 16'h5A5A, 0);
        drive(1, 11, 1, 0, 11, 0, 0);
        chk("pre_rst_valid", a_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        waitReady("rst_req", n);
        drive(1, 11, 0, 0, 0, 0, 0);
`ifdef RISC16_MEM_CLEAR_EN
        chk("after_rst11", a_rdata, 16'h0000);
`else
        chk("after_rst11", a_rdata, 16'h5A5A);
`endif
        repeat (3) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
